// File: rtl/uram_pkg.sv
// rtl/uram_pkg.sv - shared limits and helpers for the streaming URAM SDP block
package uram_pkg;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 4;

  // Upper bounds for the generic column-merge helper.
  localparam int MERGE_MAX_DW  = 1024;
  localparam int MERGE_MAX_COL = 128;
  localparam int MERGE_COL_IW  = $clog2(MERGE_MAX_COL);

  // Credits range over 0..RD_LATENCY+1.
  function automatic int credit_width(input int rd_latency);
    return $clog2(rd_latency + 2);
  endfunction

  // Replace every column whose mask bit is set with the new data.
  function automatic logic [MERGE_MAX_DW-1:0] col_merge(
    input logic [MERGE_MAX_DW-1:0]  i_old,
    input logic [MERGE_MAX_DW-1:0]  i_new,
    input logic [MERGE_MAX_COL-1:0] i_mask,
    input int                       cwidth
  );
    logic [MERGE_MAX_DW-1:0] w_res;
    int col;
    w_res = i_old;
    for (int b = 0; b < MERGE_MAX_DW; b++) begin
      col = b / cwidth;
      if (col < MERGE_MAX_COL) begin
        if (i_mask[col[MERGE_COL_IW-1:0]]) w_res[b] = i_new[b];
      end
    end
    return w_res;
  endfunction

endpackage

// File: rtl/uram_rsp_fifo.sv
// rtl/uram_rsp_fifo.sv - first-word-fall-through response buffer with empty bypass
module uram_rsp_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_in_valid,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_out_ready,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_out_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_buf [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_count == '0);

  // An empty buffer passes the incoming word straight through; it is stored
  // only if the consumer does not take it this cycle.
  assign o_out_valid = w_empty ? i_in_valid : 1'b1;
  assign o_out_data  = w_empty ? i_in_data  : r_buf[r_rd_ptr];

  assign w_push = i_in_valid && !(w_empty && i_out_ready);
  assign w_pop  = !w_empty && i_out_ready;

  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_wr_ptr] <= i_in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/uram_stream_sdp.sv
// rtl/uram_stream_sdp.sv - simple-dual-port URAM with byte-column writes and credit-flow read stream
// Optional same-edge write-to-read forwarding is enabled by macro URAM_STREAM_WR_FWD_EN.
module uram_stream_sdp
  import uram_pkg::*;
#(
  parameter int AWIDTH     = 12,
  parameter int NUM_COL    = 9,
  parameter int DWIDTH     = 72,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_valid,
  input  logic [NUM_COL-1:0] w_mask,
  input  logic [DWIDTH-1:0] w_data,
  input  logic [AWIDTH-1:0] w_address,
  input  logic              r_cmd_valid,
  input  logic [AWIDTH-1:0] r_cmd_address,
  output logic              r_cmd_ready,
  output logic              r_rsp_valid,
  output logic [DWIDTH-1:0] r_rsp_data,
  input  logic              r_rsp_ready
);

  localparam int CWIDTH    = DWIDTH / NUM_COL;
  localparam int DEPTH     = 2 ** AWIDTH;
  localparam int BUF_DEPTH = RD_LATENCY + 1;
  localparam int CRW       = credit_width(RD_LATENCY);

  generate
    if (DWIDTH % NUM_COL != 0) begin : g_bad_cwidth
      $error("uram_stream_sdp: DWIDTH must be a multiple of NUM_COL");
    end
    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
      $error("uram_stream_sdp: RD_LATENCY out of range");
    end
`ifdef URAM_STREAM_WR_FWD_EN
    if (DWIDTH > MERGE_MAX_DW || NUM_COL > MERGE_MAX_COL) begin : g_bad_merge
      $error("uram_stream_sdp: word too wide for column merge");
    end
`endif
  endgenerate

  logic [DWIDTH-1:0] r_mem [DEPTH];

  logic w_wr_en;
  logic w_cmd_fire;
  logic w_rsp_fire;

  assign w_wr_en    = w_valid && !reset;
  assign w_cmd_fire = r_cmd_valid && r_cmd_ready && !reset;
  assign w_rsp_fire = r_rsp_valid && r_rsp_ready;

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_COL; c++) begin
      if (w_wr_en && w_mask[c]) r_mem[w_address][c*CWIDTH +: CWIDTH] <= w_data[c*CWIDTH +: CWIDTH];
    end
  end

  logic [DWIDTH-1:0] w_rd_word;

`ifdef URAM_STREAM_WR_FWD_EN
  logic                    w_collide;
  logic [MERGE_MAX_DW-1:0] w_merged;

  assign w_collide = w_wr_en && (w_address == r_cmd_address);
  assign w_merged  = col_merge(MERGE_MAX_DW'(r_mem[r_cmd_address]), MERGE_MAX_DW'(w_data),
                               MERGE_MAX_COL'(w_mask), CWIDTH);
  assign w_rd_word = w_collide ? w_merged[DWIDTH-1:0] : r_mem[r_cmd_address];
`else
  // Array read sees the pre-edge contents, so a colliding write is not visible.
  assign w_rd_word = r_mem[r_cmd_address];
`endif

  logic              r_stg_vld  [RD_LATENCY];
  logic [DWIDTH-1:0] r_stg_data [RD_LATENCY];

  // The pipeline never stalls: credits guarantee buffer room for every word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) r_stg_vld[i] <= 1'b0;
    end else begin
      r_stg_vld[0] <= w_cmd_fire;
      for (int i = 1; i < RD_LATENCY; i++) r_stg_vld[i] <= r_stg_vld[i-1];
    end
    if (w_cmd_fire) r_stg_data[0] <= w_rd_word;
    for (int i = 1; i < RD_LATENCY; i++) r_stg_data[i] <= r_stg_data[i-1];
  end

  uram_rsp_fifo #(
    .WIDTH (DWIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_in_valid  (r_stg_vld[RD_LATENCY-1]),
    .i_in_data   (r_stg_data[RD_LATENCY-1]),
    .i_out_ready (r_rsp_ready),
    .o_out_valid (r_rsp_valid),
    .o_out_data  (r_rsp_data)
  );

  logic [CRW-1:0] r_credit;
  logic [CRW-1:0] w_credit_next;

  always_comb begin
    w_credit_next = r_credit;
    if (w_cmd_fire && !w_rsp_fire)      w_credit_next = r_credit + CRW'(1);
    else if (!w_cmd_fire && w_rsp_fire) w_credit_next = r_credit - CRW'(1);
  end

  // Ready is registered from the next credit value, isolating it from r_rsp_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_credit    <= '0;
      r_cmd_ready <= 1'b1;
    end else begin
      r_credit    <= w_credit_next;
      r_cmd_ready <= (w_credit_next < CRW'(BUF_DEPTH));
    end
  end

endmodule

// File: tb/tb_uram_stream_sdp.sv
// tb/tb_uram_stream_sdp.sv - scoreboard bench for uram_stream_sdp
module tb_uram_stream_sdp;

  localparam int AW = 12;
  localparam int NC = 9;
  localparam int DW = 72;
  localparam int L  = 2;
  localparam int CW = DW / NC;

  logic          clk = 1'b0;
  logic          reset;
  logic          w_valid;
  logic [NC-1:0] w_mask;
  logic [DW-1:0] w_data;
  logic [AW-1:0] w_address;
  logic          r_cmd_valid;
  logic [AW-1:0] r_cmd_address;
  logic          r_cmd_ready;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_data;
  logic          r_rsp_ready;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model [0:(1<<AW)-1];

  uram_stream_sdp #(
    .AWIDTH     (AW),
    .NUM_COL    (NC),
    .DWIDTH     (DW),
    .RD_LATENCY (L)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .w_valid       (w_valid),
    .w_mask        (w_mask),
    .w_data        (w_data),
    .w_address     (w_address),
    .r_cmd_valid   (r_cmd_valid),
    .r_cmd_address (r_cmd_address),
    .r_cmd_ready   (r_cmd_ready),
    .r_rsp_valid   (r_rsp_valid),
    .r_rsp_data    (r_rsp_data),
    .r_rsp_ready   (r_rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: in-order scoreboard plus hold-while-stalled checks.
  logic          stalled = 1'b0;
  logic [DW-1:0] held;

  always @(negedge clk) begin
    if (reset) begin
      stalled <= 1'b0;
    end else begin
      if (stalled) begin
        check("rsp_hold_valid", DW'(r_rsp_valid), DW'(1));
        check("rsp_hold_data", r_rsp_data, held);
      end
      if (r_rsp_valid && r_rsp_ready) begin
        if (exp_q.size() == 0) check("rsp_unexpected", DW'(r_rsp_valid), DW'(0));
        else check("rsp_data", r_rsp_data, exp_q.pop_front());
      end
      stalled <= r_rsp_valid && !r_rsp_ready;
      held    <= r_rsp_data;
    end
  end

  task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [NC-1:0] wm, input logic rv, input logic [AW-1:0] ra,
                       output logic fired);
    logic [DW-1:0] e;
    w_valid       = wv;
    w_address     = wa;
    w_data        = wd;
    w_mask        = wm;
    r_cmd_valid   = rv;
    r_cmd_address = ra;
    fired = rv && r_cmd_ready && !reset;
    if (fired) begin
      e = model[ra];
`ifdef URAM_STREAM_WR_FWD_EN
      if (wv && wa == ra)
        for (int c = 0; c < NC; c++) if (wm[c]) e[c*CW +: CW] = wd[c*CW +: CW];
`endif
      exp_q.push_back(e);
    end
    if (wv && !reset)
      for (int c = 0; c < NC; c++) if (wm[c]) model[wa][c*CW +: CW] = wd[c*CW +: CW];
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    logic f;
    drive(1'b0, '0, '0, '0, 1'b0, '0, f);
  endtask

  task automatic drain(input string tag);
    r_rsp_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle();
    idle();
    idle();
    check(tag, DW'(exp_q.size()), DW'(0));
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return DW'({$urandom(), $urandom(), $urandom()});
  endfunction

  initial begin
    logic f;
    int   acc;

    reset = 1'b1;
    w_valid = 1'b0; w_mask = '0; w_data = '0; w_address = '0;
    r_cmd_valid = 1'b0; r_cmd_address = '0; r_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    check("reset_rsp_valid", DW'(r_rsp_valid), DW'(0));
    check("reset_cmd_ready", DW'(r_cmd_ready), DW'(1));

    // Full-mask write, then a single read timed against RD_LATENCY.
    drive(1'b1, AW'(5), 72'h010203040506070809, '1, 1'b0, '0, f);
    check("lat_pre", DW'(r_rsp_valid), DW'(0));
    drive(1'b0, '0, '0, '0, 1'b1, AW'(5), f);
    for (int k = 1; k <= L; k++) begin
      if (k > 1) idle();
      check("rsp_latency", DW'(r_rsp_valid), DW'(k == L));
    end
    drain("drain_basic");

    // Column-0-only write.
    drive(1'b1, AW'(5), {9{8'hFF}}, 9'b000000001, 1'b0, '0, f);
    drive(1'b0, '0, '0, '0, 1'b1, AW'(5), f);
    drain("drain_mask");

    // Back-to-back reads with concurrent random writes.
    for (int a = 0; a < 16; a++) drive(1'b1, AW'(a), rnd_word(), '1, 1'b0, '0, f);
    acc = 0;
    for (int i = 0; i < 100; i++) begin
      check("cmd_ready_b2b", DW'(r_cmd_ready), DW'(1));
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), rnd_word(), NC'($urandom()),
            1'b1, AW'($urandom_range(0, 15)), f);
      if (f) acc++;
    end
    check("b2b_accepted", DW'(acc), DW'(100));
    drain("drain_b2b");

    // Backpressure fills exactly RD_LATENCY+1 credits.
    r_rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, '0, '0, '0, 1'b1, AW'(i), f);
      if (f) acc++;
    end
    check("bp_accepted", DW'(acc), DW'(L + 1));
    check("bp_cmd_ready", DW'(r_cmd_ready), DW'(0));
    drain("drain_bp");

    // Random ready pattern with random traffic.
    for (int i = 0; i < 80; i++) begin
      r_rsp_ready = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), rnd_word(), NC'($urandom()),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), f);
    end
    drain("drain_random");

    // Same-edge collision on address 7, then a later read.
    drive(1'b1, AW'(7), {9{8'h55}}, '1, 1'b0, '0, f);
    drive(1'b1, AW'(7), {9{8'hAA}}, 9'b101010101, 1'b1, AW'(7), f);
    drain("drain_collide");
    drive(1'b0, '0, '0, '0, 1'b1, AW'(7), f);
    drain("drain_after_write");

    // Reset with three responses pending; writes and reads during reset are ignored.
    r_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, '0, 1'b1, AW'(5), f);
    reset = 1'b1;
    exp_q.delete();
    drive(1'b1, AW'(5), '0, '1, 1'b1, AW'(5), f);
    check("rst_mid_rsp_valid", DW'(r_rsp_valid), DW'(0));
    check("rst_mid_cmd_ready", DW'(r_cmd_ready), DW'(1));
    reset = 1'b0;
    r_rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle();
      check("post_rst_rsp_valid", DW'(r_rsp_valid), DW'(0));
    end
    drive(1'b0, '0, '0, '0, 1'b1, AW'(5), f);
    drive(1'b0, '0, '0, '0, 1'b1, AW'(7), f);
    drain("drain_post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uram_stream_sdp.md
URAM_STREAM_SDP -- requirements
Module: uram_stream_sdp

Interface
REQ-001 SHALL have parameter AWIDTH, default 12, address width; depth = 2^AWIDTH words.
REQ-002 SHALL have parameter NUM_COL, default 9, number of byte-write columns.
REQ-003 SHALL have parameter DWIDTH, default 72, word width; CWIDTH = DWIDTH/NUM_COL.
REQ-004 SHALL have parameter RD_LATENCY, default 2, range 1..4, memory read pipeline stages.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port w_valid  input  1  write strobe; no backpressure.
REQ-008 SHALL have port w_mask  input  NUM_COL  per-column write enable.
REQ-009 SHALL have port w_data  input  DWIDTH  write data.
REQ-010 SHALL have port w_address  input  AWIDTH  write address.
REQ-011 SHALL have port r_cmd_valid  input  1  read command valid.
REQ-012 SHALL have port r_cmd_address  input  AWIDTH  read address.
REQ-013 SHALL have port r_cmd_ready  output  1  read command accept.
REQ-014 SHALL have port r_rsp_valid  output  1  read response valid.
REQ-015 SHALL have port r_rsp_data  output  DWIDTH  read response data.
REQ-016 SHALL have port r_rsp_ready  input  1  read response accept.

Function
REQ-017 SHALL write column i of mem[w_address] with w_data[i*CWIDTH +: CWIDTH] on each edge where w_valid and w_mask[i]; other columns unchanged.
REQ-018 SHALL accept a command (cmd fire) on an edge where r_cmd_valid and r_cmd_ready.
REQ-019 SHALL push fired read data through RD_LATENCY registered stages (stage 1 = URAM read, rest = pipeline registers), each with a valid bit.
REQ-020 SHALL place last-stage output into a first-word-fall-through response buffer of depth RD_LATENCY+1, bypassed when buffer empty, so r_rsp_valid rises exactly RD_LATENCY cycles after fire when idle.
REQ-021 SHALL keep a credit counter = in-flight stages + buffered entries; r_cmd_ready = (counter < RD_LATENCY+1), driven from registers only, with no combinational path from r_rsp_ready.
REQ-022 SHALL increment counter on fire, decrement on response fire (r_rsp_valid and r_rsp_ready), unchanged when both occur.
REQ-023 SHALL sustain one command and one response per cycle while r_rsp_ready is held high.
REQ-024 SHALL return responses in command order; none lost or duplicated under any r_rsp_ready pattern.
REQ-025 SHALL hold r_rsp_data stable while r_rsp_valid and not r_rsp_ready.
REQ-026 SHALL return the pre-write word when write and read fire same edge to the same address (forwarding disabled).
REQ-027 SHALL return written data for any read fired on a later edge than the write.
REQ-028 SHALL fail elaboration if DWIDTH mod NUM_COL != 0 or RD_LATENCY outside 1..4.

Reset
REQ-029 SHALL on reset clear all stage valid bits, buffer pointers and credit counter; r_rsp_valid = 0, r_cmd_ready = 1 the cycle after reset deasserts.
REQ-030 SHALL discard in-flight and buffered responses when reset asserts mid-operation; memory contents and r_rsp_data SHALL not be reset.
REQ-031 SHALL ignore w_valid and r_cmd_valid while reset is high.

Configuration
REQ-032 SHALL, with macro URAM_STREAM_WR_FWD_EN defined, return on a same-edge same-address collision the read word with masked columns replaced by w_data (new data per column).
REQ-033 SHALL, with URAM_STREAM_WR_FWD_EN undefined, behave per REQ-026 with no forwarding logic.

Structure
REQ-034 SHALL place RD_LATENCY range limits, credit-counter width function and column-merge function in shared package uram_pkg.
REQ-035 SHALL implement the response buffer as sub-module uram_rsp_fifo (FWFT, parametrised width/depth, with empty bypass).

Verification
REQ-036 SHALL cover: write 0x0102..09 to addr 5 full mask; read 5 at cycle t -> r_rsp_valid at t+RD_LATENCY, data 0x0102..09.
REQ-037 SHALL cover: mask 9'b000000001 writes 0xFF to addr 5 -> read returns only column 0 changed.
REQ-038 SHALL cover: 100 back-to-back reads, r_rsp_ready=1 -> 100 in-order responses, r_cmd_ready never low.
REQ-039 SHALL cover: r_rsp_ready=0 for 10 cycles with r_cmd_valid=1 -> exactly RD_LATENCY+1 commands accepted, then r_cmd_ready=0; release -> all returned in order.
REQ-040 SHALL cover: same-edge write 0xAA.. / read addr 7 holding 0x55.. -> 0x55.. without macro, 0xAA.. (masked columns) with URAM_STREAM_WR_FWD_EN.
REQ-041 SHALL cover: reset asserted with 3 responses pending -> r_rsp_valid=0 next cycle, no stale response afterwards, prior memory contents readable.
